id_ex_skid_stage: RTL and testbench
===================================

// Module: id_ex_skid_stage
// PURPOSE
//  Parametrised ID/EX pipeline stage with valid/ready handshake and a 2-entry skid buffer.
//  Carries decoded control, operands PA/PB, PC, RS address and destination register from ID to EX.
//  Supports back-pressure from EX (stall without combinational ready path) and flush (bubble insertion).
//  Sits between the decode/register-file read and the execute stage.
// PARAMETERS
//  CTRL_W      24  width of control signal bundle
//  DATA_W      32  width of PA, PB, PC, RS_Address
//  REG_AW      5   width of destination register index
//  CNT_W       16  width of performance counters (ID_EX_PERF_CNT_EN only)
// PORTS
//  clk                  in   1        clock, all state on rising edge
//  reset                in   1        synchronous, active-low reset (0 = reset)
//  flush                in   1        discard all held entries; highest priority after reset
//  in_valid             in   1        ID presents a valid instruction
//  in_ready             out  1        stage can accept this cycle
//  control_signals      in   CTRL_W   decoded control bundle
//  PA, PB, PC           in   DATA_W   operand A, operand B, program counter
//  RS_Address           in   DATA_W   RS address/value
//  destination          in   REG_AW   destination register index
//  out_valid            out  1        head entry valid toward EX
//  out_ready            in   1        EX consumes head this cycle
//  control_signals_out  out  CTRL_W   head payload (same for all *_out)
//  PA_out, PB_out, PC_out, RS_Address_out  out  DATA_W
//  destination_out      out  REG_AW
//  stall_cnt            out  CNT_W    [macro] cycles with out_valid & !out_ready
//  bubble_cnt           out  CNT_W    [macro] cycles with !out_valid
// BEHAVIOUR
//  - reset==0 at edge: state EMPTY, out_valid=0, all *_out=0, in_ready=1 next cycle, counters=0.
//  - accept = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (state != FULL); driven from state register only, no comb path from out_ready.
//  - Latency: accepted instruction appears on *_out with out_valid=1 the next cycle when EMPTY.
//  - States / transitions (state register, 2 bits):
//      EMPTY: accept -> ONE (head<=in); else stay.
//      ONE:   accept&!pop -> FULL (skid<=in); pop&!accept -> EMPTY; accept&pop -> ONE (head<=in).
//      FULL:  pop -> ONE (head<=skid); else stay; accept impossible (in_ready=0).
//  - Head payload stable while out_valid & !out_ready (no change on any *_out).
//  - Entry leaving to EMPTY zeroes head payload: *_out are all zero whenever out_valid=0 (NOP bubble).
//  - flush=1: next state EMPTY, both entries zeroed; same-cycle accept is dropped; same-cycle pop
//    still counts as consumed by EX. in_ready=1 the cycle after flush.
//  - Priority: reset > flush > accept/pop.
//  - No arithmetic on payload; widths pass through unchanged; inputs zero-extended nowhere.
// CONFIGURATION
//  ID_EX_PERF_CNT_EN defined: stall_cnt and bubble_cnt ports present; each increments by 1 per
//    qualifying cycle, saturates at 2^CNT_W-1, cleared by reset only (not flush).
//  Undefined: ports and counter logic absent; CNT_W unused.
// STRUCTURE
//  - Package id_ex_pkg: state encoding localparams (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2),
//    default widths CTRL_W/DATA_W/REG_AW.
//  - Sub-module id_ex_entry: one payload register slice (load, clear, hold), instantiated twice
//    (head, skid). FSM and counters in top.
// TESTING
//  1 Reset: reset=0 two cycles with in_valid=1 -> out_valid=0, all *_out=0, in_ready=1 after release.
//  2 Pass-through: out_ready=1, send PC=0x100,0x104,0x108 back-to-back -> each on PC_out 1 cycle
//    later, out_valid continuous, in_ready never drops.
//  3 Stall/skid: out_ready=0, send PC=0x200,0x204 -> in_ready=0 after 2nd; PC_out holds 0x200;
//    raise out_ready -> 0x200 then 0x204 in consecutive cycles, no loss or duplicate.
//  4 Flush: FULL state, assert flush with in_valid=1 PC=0x300 -> next cycle out_valid=0,
//    all *_out=0, in_ready=1; 0x300 never appears.
//  5 Simultaneous accept+pop in ONE: head PC=0x400, send 0x404 with out_ready=1 -> PC_out=0x404
//    next cycle, state ONE.
//  6 [ID_EX_PERF_CNT_EN, CNT_W=4] hold out_valid&!out_ready 20 cycles -> stall_cnt=15 saturated;
//    flush does not clear it; reset does.

Source files
------------

// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX skid stage.
//   ST_EMPTY / ST_ONE / ST_FULL : occupancy state encoding (2 bits)
//   *_W_DEF                     : default payload widths
// Optional feature macro used by the top: ID_EX_PERF_CNT_EN
package id_ex_pkg;

  localparam int CTRL_W_DEF = 24;
  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } id_ex_state_e;

endpackage

// File: rtl/id_ex_entry.sv
// One payload register slice of the ID/EX stage (used for head and skid).
// Ports:
//   clk    in  clock
//   reset  in  synchronous active-low reset, zeroes the slice
//   clear  in  zero the slice (takes priority over load)
//   load   in  capture d
//   d      in  W-bit payload
//   q      out W-bit held payload
module id_ex_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// Carries control bundle, PA, PB, PC, RS_Address and destination from ID to EX.
// in_ready depends only on the state register, so there is no combinational
// path from out_ready back to in_ready.
// Ports:
//   clk, reset (sync, active-low), flush
//   in_valid / in_ready, control_signals, PA, PB, PC, RS_Address, destination
//   out_valid / out_ready, *_out head payload (all zero while out_valid=0)
//   stall_cnt, bubble_cnt : saturating perf counters, present only when the
//                           ID_EX_PERF_CNT_EN macro is defined
//
// state    | meaning
// ---------+------------------------------------------
// ST_EMPTY | no entry held, *_out zero
// ST_ONE   | head holds one entry, skid empty
// ST_FULL  | head and skid both hold entries, in_ready=0
module id_ex_skid_stage
  import id_ex_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
`ifdef ID_EX_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] control_signals,
  input  logic [DATA_W-1:0] PA,
  input  logic [DATA_W-1:0] PB,
  input  logic [DATA_W-1:0] PC,
  input  logic [DATA_W-1:0] RS_Address,
  input  logic [REG_AW-1:0] destination,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] control_signals_out,
  output logic [DATA_W-1:0] PA_out,
  output logic [DATA_W-1:0] PB_out,
  output logic [DATA_W-1:0] PC_out,
  output logic [DATA_W-1:0] RS_Address_out,
  output logic [REG_AW-1:0] destination_out
`ifdef ID_EX_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] bubble_cnt
`endif
);

  localparam int PAY_W = CTRL_W + 4 * DATA_W + REG_AW;

  id_ex_state_e r_state;
  id_ex_state_e w_state_nxt;

  logic             w_accept;
  logic             w_pop;
  logic             w_head_load;
  logic             w_head_clear;
  logic             w_head_from_skid;
  logic             w_skid_load;
  logic             w_skid_clear;
  logic [PAY_W-1:0] w_in_pay;
  logic [PAY_W-1:0] w_head_d;
  logic [PAY_W-1:0] w_head_q;
  logic [PAY_W-1:0] w_skid_q;

  assign in_ready  = (r_state != ST_FULL);
  assign out_valid = (r_state != ST_EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign w_in_pay = {control_signals, PA, PB, PC, RS_Address, destination};
  assign w_head_d = w_head_from_skid ? w_skid_q : w_in_pay;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_head_load      = 1'b0;
    w_head_clear     = 1'b0;
    w_head_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    if (flush) begin
      // Any same-cycle accept is dropped; a same-cycle pop is already consumed by EX.
      w_state_nxt  = ST_EMPTY;
      w_head_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_ONE;
            w_head_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && !w_pop) begin
            w_state_nxt = ST_FULL;
            w_skid_load = 1'b1;
          end else if (w_pop && !w_accept) begin
            // Zero the head so *_out present a NOP bubble while empty.
            w_state_nxt  = ST_EMPTY;
            w_head_clear = 1'b1;
          end else if (w_accept && w_pop) begin
            w_head_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_state_nxt      = ST_ONE;
            w_head_load      = 1'b1;
            w_head_from_skid = 1'b1;
            w_skid_clear     = 1'b1;
          end
        end
        default: begin
          w_state_nxt  = ST_EMPTY;
          w_head_clear = 1'b1;
          w_skid_clear = 1'b1;
        end
      endcase
    end
  end

  id_ex_entry #(.W(PAY_W)) u_head (
    .clk   (clk),
    .reset (reset),
    .clear (w_head_clear),
    .load  (w_head_load),
    .d     (w_head_d),
    .q     (w_head_q)
  );

  id_ex_entry #(.W(PAY_W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .clear (w_skid_clear),
    .load  (w_skid_load),
    .d     (w_in_pay),
    .q     (w_skid_q)
  );

  assign {control_signals_out, PA_out, PB_out, PC_out, RS_Address_out, destination_out} = w_head_q;

`ifdef ID_EX_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Cleared by reset only; flush leaves the statistics intact.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (!out_valid && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_skid_stage.sv
module tb_id_ex_skid_stage;

  localparam int CTRL_W = 24;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
`ifdef ID_EX_PERF_CNT_EN
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] control_signals = '0;
  logic [DATA_W-1:0] PA = '0, PB = '0, PC = '0, RS_Address = '0;
  logic [REG_AW-1:0] destination = '0;
  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] control_signals_out;
  logic [DATA_W-1:0] PA_out, PB_out, PC_out, RS_Address_out;
  logic [REG_AW-1:0] destination_out;
`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;
  int                m_stall = 0, m_bubble = 0;
`endif

  always #5 clk = ~clk;

  id_ex_skid_stage #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .REG_AW(REG_AW)
`ifdef ID_EX_PERF_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .control_signals(control_signals), .PA(PA), .PB(PB), .PC(PC),
    .RS_Address(RS_Address), .destination(destination),
    .out_valid(out_valid), .out_ready(out_ready),
    .control_signals_out(control_signals_out), .PA_out(PA_out), .PB_out(PB_out),
    .PC_out(PC_out), .RS_Address_out(RS_Address_out), .destination_out(destination_out)
`ifdef ID_EX_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] pa;
    logic [DATA_W-1:0] pb;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs;
    logic [REG_AW-1:0] dest;
  } pay_t;

  // Reference model: an in-order queue of at most two entries.
  pay_t mq[$];
  int   n_assert = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit   m_in_ready, m_out_valid, acc, pp;
    pay_t p;
    m_in_ready  = (mq.size() < 2);
    m_out_valid = (mq.size() > 0);
    acc = in_valid && m_in_ready;
    pp  = m_out_valid && out_ready;
    p   = {control_signals, PA, PB, PC, RS_Address, destination};
`ifdef ID_EX_PERF_CNT_EN
    if (!reset) begin
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (m_out_valid && !out_ready && m_stall < CNT_MAX) m_stall++;
      if (!m_out_valid && m_bubble < CNT_MAX) m_bubble++;
    end
`endif
    if (!reset || flush) begin
      mq.delete();
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(p);
    end
  endtask

  task automatic check_all();
    pay_t e;
    e = (mq.size() > 0) ? mq[0] : pay_t'(0);
    chk("out_valid", 160'(out_valid), 160'(mq.size() > 0));
    chk("in_ready", 160'(in_ready), 160'(mq.size() < 2));
    chk("ctrl_out", 160'(control_signals_out), 160'(e.ctrl));
    chk("PA_out", 160'(PA_out), 160'(e.pa));
    chk("PB_out", 160'(PB_out), 160'(e.pb));
    chk("PC_out", 160'(PC_out), 160'(e.pc));
    chk("RS_out", 160'(RS_Address_out), 160'(e.rs));
    chk("dest_out", 160'(destination_out), 160'(e.dest));
`ifdef ID_EX_PERF_CNT_EN
    chk("stall_cnt", 160'(stall_cnt), 160'(m_stall));
    chk("bubble_cnt", 160'(bubble_cnt), 160'(m_bubble));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic drive(input logic [DATA_W-1:0] pc);
    in_valid        = 1'b1;
    control_signals = CTRL_W'($urandom);
    PA              = $urandom;
    PB              = $urandom;
    RS_Address      = $urandom;
    destination     = REG_AW'($urandom);
    PC              = pc;
  endtask

  initial begin
    // Reset held two cycles with a valid request pending
    reset = 1'b0;
    drive(32'h999);
    cycle();
    cycle();
    chk("rst_out_valid", 160'(out_valid), 160'(0));
    chk("rst_pc_out", 160'(PC_out), 160'(0));
    in_valid = 1'b0;
    reset    = 1'b1;
    cycle();
    chk("rst_in_ready", 160'(in_ready), 160'(1));

    // Pass-through
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h100 + 32'(4 * i));
      cycle();
      chk("pass_pc", 160'(PC_out), 160'(32'h100 + 32'(4 * i)));
      chk("pass_in_ready", 160'(in_ready), 160'(1));
      chk("pass_valid", 160'(out_valid), 160'(1));
    end
    in_valid = 1'b0;
    cycle();

    // Stall and skid
    out_ready = 1'b0;
    drive(32'h200);
    cycle();
    drive(32'h204);
    cycle();
    chk("skid_in_ready", 160'(in_ready), 160'(0));
    chk("skid_hold", 160'(PC_out), 160'(32'h200));
    in_valid = 1'b0;
    cycle();
    chk("skid_hold2", 160'(PC_out), 160'(32'h200));
    out_ready = 1'b1;
    cycle();
    chk("skid_second", 160'(PC_out), 160'(32'h204));
    cycle();
    chk("skid_drained", 160'(out_valid), 160'(0));

    // Flush from FULL with a same-cycle request
    out_ready = 1'b0;
    drive(32'h3a0);
    cycle();
    drive(32'h3a4);
    cycle();
    drive(32'h300);
    flush = 1'b1;
    cycle();
    chk("flush_valid", 160'(out_valid), 160'(0));
    chk("flush_pc", 160'(PC_out), 160'(0));
    chk("flush_in_ready", 160'(in_ready), 160'(1));
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      cycle();
      chk("flush_no_300", 160'(out_valid), 160'(0));
    end

    // Simultaneous accept and pop in ONE
    out_ready = 1'b0;
    drive(32'h400);
    cycle();
    drive(32'h404);
    out_ready = 1'b1;
    cycle();
    chk("acc_pop_pc", 160'(PC_out), 160'(32'h404));
    chk("acc_pop_valid", 160'(out_valid), 160'(1));
    chk("acc_pop_ready", 160'(in_ready), 160'(1));
    in_valid = 1'b0;
    cycle();

`ifdef ID_EX_PERF_CNT_EN
    // Stall counter saturation, flush immunity, reset clear
    out_ready = 1'b0;
    drive(32'h500);
    cycle();
    in_valid = 1'b0;
    repeat (20) cycle();
    chk("stall_sat", 160'(stall_cnt), 160'(15));
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("stall_after_flush", 160'(stall_cnt), 160'(15));
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    chk("stall_after_reset", 160'(stall_cnt), 160'(0));
`endif

    // Randomized traffic against the queue model
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(1, 0) != 0) drive($urandom);
      else in_valid = 1'b0;
      out_ready = ($urandom_range(3, 0) != 0);
      flush     = ($urandom_range(15, 0) == 0);
      reset     = ($urandom_range(63, 0) != 0);
      cycle();
    end
    reset = 1'b1;
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
